// File: rtl/ping_sequencer_if.sv
// Control/status bundle between the I2C register file (master) and the
// ping sequencer (slave). Clock and reset travel as plain ports.
interface ping_sequencer_if #(
    parameter int CW  = 16,
    parameter int PCW = 8
);
    logic           start;
    logic           abort;
    logic           cont;
    logic [CW-1:0]  burst_len;
    logic [CW-1:0]  brake_len;
    logic [CW-1:0]  blank_len;
    logic [CW-1:0]  listen_len;
    logic [1:0]     hstate;
    logic           txrx;
    logic           sample_en;
    logic           busy;
    logic           done;
    logic [PCW-1:0] ping_count;

    modport master (
        output start, abort, cont, burst_len, brake_len, blank_len, listen_len,
        input  hstate, txrx, sample_en, busy, done, ping_count
    );

    modport slave (
        input  start, abort, cont, burst_len, brake_len, blank_len, listen_len,
        output hstate, txrx, sample_en, busy, done, ping_count
    );
endinterface

// File: rtl/ping_sequencer.sv
// Sequences one DVL ping: BURST -> BRAKE -> BLANK -> LISTEN, skipping
// zero-length phases, with registered h_bridge / txrx / sampling outputs
// decoded from the next state. Phase lengths are shadowed at start.
module ping_sequencer #(
    parameter int CW  = 16,
    parameter int PCW = 8
) (
    input  logic             hsclk,
    input  logic             rst,
    ping_sequencer_if.slave  bus
);
    localparam logic [1:0] HB_OFF   = 2'b00;
    localparam logic [1:0] HB_OSCL  = 2'b01;
    localparam logic [1:0] HB_BRAKE = 2'b10;

    // S_ZDONE is the one-cycle exit used when every phase length is zero.
    typedef enum logic [2:0] {
        S_IDLE, S_BURST, S_BRAKE, S_BLANK, S_LISTEN, S_ZDONE
    } state_t;

    typedef struct packed {
        logic [CW-1:0] burst;
        logic [CW-1:0] brake;
        logic [CW-1:0] blank;
        logic [CW-1:0] listen;
    } cfg_t;

    state_t        state;
    state_t        nxt_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] nxt_cnt;
    cfg_t          shadow;
    cfg_t          nxt_cfg;
    cfg_t          live;
    logic          finish;

    assign live = {bus.burst_len, bus.brake_len, bus.blank_len, bus.listen_len};

    // First phase with a nonzero length, or S_ZDONE when there is none.
    function automatic state_t first_phase(input cfg_t c);
        if (c.burst  != '0) return S_BURST;
        if (c.brake  != '0) return S_BRAKE;
        if (c.blank  != '0) return S_BLANK;
        if (c.listen != '0) return S_LISTEN;
        return S_ZDONE;
    endfunction

    // Next nonzero phase after s; S_IDLE marks the end of the ping.
    function automatic state_t next_after(input state_t s, input cfg_t c);
        cfg_t   m;
        state_t f;
        m = c;
        m.burst = '0;
        if (s != S_BURST)                    m.brake = '0;
        if (s == S_BLANK || s == S_LISTEN)   m.blank = '0;
        if (s == S_LISTEN)                   m.listen = '0;
        f = first_phase(m);
        return (f == S_ZDONE) ? S_IDLE : f;
    endfunction

    // Counter value on phase entry: len-1, so the phase ends when it reaches 0.
    function automatic logic [CW-1:0] load_val(input state_t s, input cfg_t c);
        case (s)
            S_BURST:  return c.burst  - CW'(1);
            S_BRAKE:  return c.brake  - CW'(1);
            S_BLANK:  return c.blank  - CW'(1);
            S_LISTEN: return c.listen - CW'(1);
            default:  return '0;
        endcase
    endfunction

    // Next-state, counter and shadow-config selection.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_cfg   = shadow;
        finish    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    nxt_cfg   = live;
                    nxt_state = first_phase(live);
                    nxt_cnt   = load_val(nxt_state, live);
                    finish    = (nxt_state == S_ZDONE);
                end
            end
            S_ZDONE: begin
                nxt_state = S_IDLE;
            end
            default: begin
                if (bus.abort) begin
                    nxt_state = S_IDLE;
                    nxt_cnt   = '0;
                end else if (cnt != '0) begin
                    nxt_cnt = cnt - CW'(1);
                end else begin
                    nxt_state = next_after(state, shadow);
                    if (nxt_state == S_IDLE) begin
                        finish = 1'b1;
                        if (bus.cont) begin
                            nxt_cfg   = live;
                            nxt_state = first_phase(live);
                            if (nxt_state == S_ZDONE) nxt_state = S_IDLE;
                        end
                    end
                    nxt_cnt = load_val(nxt_state, nxt_cfg);
                end
            end
        endcase
    end

    // State, counter, shadow config and registered outputs decoded from next state.
    always_ff @(posedge hsclk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            shadow         <= '0;
            bus.hstate     <= HB_OFF;
            bus.txrx       <= 1'b0;
            bus.sample_en  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.ping_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state         <= nxt_state;
            cnt           <= nxt_cnt;
            shadow        <= nxt_cfg;
            bus.hstate    <= (nxt_state == S_BURST) ? HB_OSCL :
                             (nxt_state == S_BRAKE) ? HB_BRAKE : HB_OFF;
            bus.txrx      <= (nxt_state == S_BURST) || (nxt_state == S_BRAKE) ||
                             (nxt_state == S_BLANK);
            bus.sample_en <= (nxt_state == S_LISTEN);
            bus.busy      <= (nxt_state != S_IDLE);
            bus.done      <= finish;
            if (finish) bus.ping_count <= bus.ping_count + PCW'(1);
        end
    end
endmodule

// File: tb/tb_ping_sequencer.sv
// Self-checking bench for ping_sequencer: constant vector table, hand-written
// corner sequences, and randomized pings against a phase-list reference model.
module tb_ping_sequencer;
    localparam int CW  = 16;
    localparam int PCW = 8;
    localparam logic [1:0] HB_OFF   = 2'b00;
    localparam logic [1:0] HB_OSCL  = 2'b01;
    localparam logic [1:0] HB_BRAKE = 2'b10;

    logic hsclk = 1'b0;
    logic rst   = 1'b1;

    ping_sequencer_if #(.CW(CW), .PCW(PCW)) bus ();
    ping_sequencer #(.CW(CW), .PCW(PCW)) dut (.hsclk(hsclk), .rst(rst), .bus(bus));

    always #5 hsclk = ~hsclk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [PCW-1:0] model_count = '0;

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic [1:0]     hs;
        logic           tx;
        logic           se;
        logic           busy;
        logic           done;
    } obs_t;

    typedef struct {
        int b, k, s, l;
        int n_oscl, n_brake, n_samp, n_tx, done_cyc, done_busy;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hsclk);
        #1;
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.pc = bus.ping_count; o.hs = bus.hstate; o.tx = bus.txrx;
        o.se = bus.sample_en;  o.busy = bus.busy; o.done = bus.done;
        return o;
    endfunction

    function automatic obs_t mk(input logic [PCW-1:0] pc, input logic [1:0] hs,
                                input logic tx, input logic se, input logic busy,
                                input logic done);
        obs_t o;
        o.pc = pc; o.hs = hs; o.tx = tx; o.se = se; o.busy = busy; o.done = done;
        return o;
    endfunction

    // Expected timeline: each nonzero phase contributes len cycles, then the
    // done cycle, then idle. An abort truncates after its cycle.
    task automatic run_ping(input string tag, input int b, input int k, input int s,
                            input int l, input int abort_at, input int start_at,
                            input int chg_at, input int chg_val, input bit noise);
        obs_t q[$];
        int lens[4];
        logic [PCW-1:0] pc0, pc1;
        pc0 = model_count;
        pc1 = pc0 + 1'b1;
        lens[0] = b; lens[1] = k; lens[2] = s; lens[3] = l;
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < lens[p]; c++)
                q.push_back(mk(pc0, (p == 0) ? HB_OSCL : (p == 1) ? HB_BRAKE : HB_OFF,
                               p != 3, p == 3, 1'b1, 1'b0));
        if (q.size() == 0) q.push_back(mk(pc1, HB_OFF, 1'b0, 1'b0, 1'b1, 1'b1));
        else               q.push_back(mk(pc1, HB_OFF, 1'b0, 1'b0, 1'b0, 1'b1));
        q.push_back(mk(pc1, HB_OFF, 1'b0, 1'b0, 1'b0, 1'b0));
        if (abort_at > 0) begin
            while (q.size() > abort_at) void'(q.pop_back());
            q.push_back(mk(pc0, HB_OFF, 1'b0, 1'b0, 1'b0, 1'b0));
            q.push_back(mk(pc0, HB_OFF, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        model_count = q[q.size()-1].pc;

        bus.burst_len = CW'(b); bus.brake_len = CW'(k);
        bus.blank_len = CW'(s); bus.listen_len = CW'(l);
        bus.abort = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= q.size(); i++) begin
            check($sformatf("%s cyc%0d", tag, i), observe(), q[i-1]);
            bus.abort = (i == abort_at);
            bus.start = (i == start_at) || (noise && q[i-1].busy && ($urandom_range(0, 3) == 0));
            if (i == chg_at) bus.burst_len = CW'(chg_val);
            if (noise) begin
                bus.burst_len  = CW'($urandom_range(0, 20));
                bus.brake_len  = CW'($urandom_range(0, 20));
                bus.blank_len  = CW'($urandom_range(0, 20));
                bus.listen_len = CW'($urandom_range(0, 20));
            end
            if (i < q.size()) tick();
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
    endtask

    vec_t vecs[6];
    int n_oscl, n_brake, n_samp, n_tx, done_cyc, done_busy;
    int rb, rk, rs, rl, tot, ab;

    initial begin
        // Vector table: lengths and hand-derived phase occupancy counts.
        vecs[0] = '{4, 2, 3, 5, 4, 2, 5, 9, 15, 0};
        vecs[1] = '{3, 0, 0, 2, 3, 0, 2, 3,  6, 0};
        vecs[2] = '{0, 0, 0, 0, 0, 0, 0, 0,  1, 1};
        vecs[3] = '{0, 0, 0, 4, 0, 0, 4, 0,  5, 0};
        vecs[4] = '{1, 1, 1, 1, 1, 1, 1, 3,  5, 0};
        vecs[5] = '{0, 2, 0, 0, 0, 2, 0, 2,  3, 0};

        bus.start = 1'b0; bus.abort = 1'b0; bus.cont = 1'b0;
        bus.burst_len = '0; bus.brake_len = '0; bus.blank_len = '0; bus.listen_len = '0;

        // Reset state, and start ignored while reset is still high at the edge.
        bus.start = 1'b1;
        tick();
        check("reset state", observe(), '0);
        bus.start = 1'b0;
        rst = 1'b0;
        tick();
        check("idle after reset", observe(), '0);

        // Table-driven vectors.
        foreach (vecs[v]) begin
            bus.burst_len = CW'(vecs[v].b); bus.brake_len = CW'(vecs[v].k);
            bus.blank_len = CW'(vecs[v].s); bus.listen_len = CW'(vecs[v].l);
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            n_oscl = 0; n_brake = 0; n_samp = 0; n_tx = 0; done_cyc = 0; done_busy = -1;
            for (int i = 1; i <= 60; i++) begin
                check($sformatf("vec%0d no overlap cyc%0d", v, i),
                      {30'd0, bus.hstate == 2'b11, bus.txrx & bus.sample_en}, '0);
                if (bus.hstate == HB_OSCL)  n_oscl++;
                if (bus.hstate == HB_BRAKE) n_brake++;
                if (bus.sample_en) n_samp++;
                if (bus.txrx)      n_tx++;
                if (bus.done) begin
                    done_cyc = i;
                    done_busy = int'(bus.busy);
                    break;
                end
                tick();
            end
            model_count = model_count + 1'b1;
            check($sformatf("vec%0d oscl", v),  n_oscl,  vecs[v].n_oscl);
            check($sformatf("vec%0d brake", v), n_brake, vecs[v].n_brake);
            check($sformatf("vec%0d sample", v), n_samp, vecs[v].n_samp);
            check($sformatf("vec%0d txrx", v),  n_tx,    vecs[v].n_tx);
            check($sformatf("vec%0d done cycle", v), done_cyc, vecs[v].done_cyc);
            check($sformatf("vec%0d done busy", v), done_busy, vecs[v].done_busy);
            check($sformatf("vec%0d count", v), bus.ping_count, model_count);
            tick();
        end

        // Hand-written sequences.
        run_ping("nominal", 4, 2, 3, 5, 0, 0, 0, 0, 1'b0);
        run_ping("zero skip", 3, 0, 0, 2, 0, 0, 0, 0, 1'b0);
        run_ping("abort", 6, 2, 2, 2, 2, 1, 0, 0, 1'b0);
        run_ping("isolate", 4, 2, 1, 2, 0, 0, 5, 10, 1'b0);
        run_ping("isolate next", 10, 2, 1, 2, 0, 0, 0, 0, 1'b0);

        // Randomized pings with mid-ping noise on start and config.
        for (int t = 0; t < 40; t++) begin
            rb = $urandom_range(0, 5); rk = $urandom_range(0, 5);
            rs = $urandom_range(0, 5); rl = $urandom_range(0, 5);
            tot = rb + rk + rs + rl;
            ab = 0;
            if (tot > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, tot);
            run_ping("rand", rb, rk, rs, rl, ab, 0, 0, 0, 1'b1);
        end

        // Asynchronous reset in the middle of BURST.
        bus.burst_len = 16'd10; bus.brake_len = 16'd2;
        bus.blank_len = 16'd2;  bus.listen_len = 16'd2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("pre-reset burst", {30'd0, bus.hstate}, HB_OSCL);
        #2 rst = 1'b1;
        #1 check("async reset mid-burst", observe(), '0);
        tick();
        rst = 1'b0;
        model_count = '0;
        tick();
        check("idle after mid-burst reset", observe(), '0);

        // Continuous mode: 255 pings, then wrap to 0, then stop via cont=0.
        bus.cont = 1'b1;
        bus.burst_len = 16'd1; bus.brake_len = 16'd0;
        bus.blank_len = 16'd0; bus.listen_len = 16'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 514; i++) begin
            check($sformatf("cont busy cyc%0d", i), bus.busy, 1'b1);
            check($sformatf("cont done cyc%0d", i), bus.done, (i >= 3) && (i % 2 == 1));
            if (i == 511) check("cont count 255", bus.ping_count, 8'd255);
            if (i == 513) check("cont count wrap", bus.ping_count, 8'd0);
            if (i == 514) bus.cont = 1'b0;
            tick();
        end
        check("cont final", observe(), mk(8'd1, HB_OFF, 1'b0, 1'b0, 1'b0, 1'b1));
        tick();
        check("cont idle", observe(), mk(8'd1, HB_OFF, 1'b0, 1'b0, 1'b0, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ping_sequencer.md
# ping_sequencer

Sequences one DVL ping: it drives the `h_bridge` state input through oscillate, brake, blanking and listen phases, controls the `txrx` transmit/receive switch, and gates ADC sampling during the listen window. It sits between the I2C register file, which supplies the config, start and abort, and the `h_bridge` / ADC capture path. Phase lengths are latched at start so that I2C writes during a ping cannot disturb it.

## Interface
Parameters:
- `CW`, 16, width of the phase-length counters and config fields.
- `PCW`, 8, width of `ping_count`.

Ports:
- `hsclk` in 1: system clock from the HSOSC.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle request to begin a ping. Ignored while `busy`.
- `abort` in 1: terminates the current ping.
- `cont` in 1: continuous mode. Sampled at the end of LISTEN.
- `burst_len` in CW: oscillation length in `hsclk` cycles.
- `brake_len` in CW: brake (ring-down) length in cycles.
- `blank_len` in CW: blanking length in cycles.
- `listen_len` in CW: listen window length in cycles.
- `hstate` out 2: h_bridge command. Codes from dvl_params.sv: `HB_OFF`=2'b00, `HB_OSCL`=2'b01, `HB_BRAKE`=2'b10. 2'b11 is never driven.
- `txrx` out 1: 1 selects the transmit path, 0 selects the receiver.
- `sample_en` out 1: ADC capture enable.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on normal ping completion.
- `ping_count` out PCW: number of completed pings.

## Operation
States:

| State | `hstate` | `txrx` | `sample_en` |
|---|---|---|---|
| IDLE | HB_OFF | 0 | 0 |
| BURST | HB_OSCL | 1 | 0 |
| BRAKE | HB_BRAKE | 1 | 0 |
| BLANK | HB_OFF | 1 | 0 |
| LISTEN | HB_OFF | 0 | 1 |

- All outputs are registered and decoded from the next state, so outputs change on the same edge as the state.
- In IDLE, `start` latches the four lengths into shadow registers and moves to the first phase with a nonzero length. Phase order is BURST, BRAKE, BLANK, LISTEN.
- Each phase lasts exactly its latched length in cycles:
  - A down-counter is loaded with len-1 on entry.
  - The phase exits when the counter is 0.
  - Phases with length 0 are skipped; the state goes directly to the next nonzero phase.
- End of LISTEN, or of the last nonzero phase:
  - `done` pulses and `ping_count` increments, wrapping from 2^PCW-1 to 0.
  - If `cont`=1, the sequencer reloads the shadow config and re-enters the first nonzero phase with no IDLE cycle. `busy` stays 1.
  - If `cont`=0, it goes to IDLE.
- All four lengths zero: `start` yields `busy`=1 for one cycle and `done`=1 in that same cycle, then IDLE. The sequencer uses a transient IDLE-exit state for this case. `hstate`/`txrx` are never changed.
- `abort` in any non-IDLE state goes to IDLE on the next edge:
  - `hstate`=HB_OFF, `txrx`=0, `sample_en`=0.
  - No `done` pulse; `ping_count` is unchanged.
  - `abort` has priority over phase exit and over `cont` restart. It has no effect in IDLE, and `start` is then ignored in the same cycle as `abort`.
- `start` while `busy` is ignored. It is not queued.
- Config inputs changing mid-ping have no effect until the next `start` or continuous restart.

## Timing
- Reset (async assert) values: state IDLE, `hstate`=HB_OFF, `txrx`=0, `sample_en`=0, `busy`=0, `done`=0, `ping_count`=0, counters and shadow registers 0. Outputs take these values immediately on assertion.
- Reset deassertion takes effect at the next `hsclk` edge. No start is accepted in the deassertion cycle if `rst` is still high at that edge.
- Latency: `start` sampled at edge t gives `busy`=1 and the first phase outputs valid after edge t.
- With lengths B, K, S, L all nonzero:
  - BURST covers edges t..t+B-1 (B cycles).
  - BRAKE covers the next K cycles, then BLANK S cycles, then LISTEN L cycles.
  - `done` is high for the single cycle after the last LISTEN cycle. In that cycle `busy`=0 (when `cont`=0) and `ping_count` shows the incremented value.
- `txrx` falls on the same edge that `sample_en` rises. There is no overlap of transmit and sampling.
- `hstate` never goes from HB_OSCL to HB_OFF directly except via abort or `brake_len`=0.

## Test plan
- Reset mid-BURST: assert `rst` asynchronously during BURST → all outputs go to reset values without a clock edge, and `ping_count`=0.
- Nominal ping: B=4, K=2, S=3, L=5, `start` at cycle 0 →
  - `hstate` OSCL in cycles 1–4, BRAKE in 5–6, OFF otherwise.
  - `txrx`=1 in cycles 1–9.
  - `sample_en`=1 in cycles 10–14.
  - `done` in cycle 15 and `ping_count`=1.
- Zero-length skip: B=3, K=0, S=0, L=2 → OSCL in cycles 1–3, `sample_en` in cycles 4–5, `done` in cycle 6, and `hstate` never equals HB_BRAKE.
- Abort and ignored start: assert `abort` in the 2nd BURST cycle → IDLE with HB_OFF on the next edge, no `done`, `ping_count` unchanged. A `start` pulsed during the ping (before the abort) has no effect.
- Continuous mode and wrap: `cont`=1, B=1, K=0, S=0, L=1, `ping_count` preloaded to 255 by running 255 pings → `busy` stays 1 across pings, `done` pulses every 2 cycles, and `ping_count` wraps 255→0.
- Config isolation: change `burst_len` from 4 to 10 during BRAKE → the current ping is unchanged, and the next `start` gives a 10-cycle BURST.
